// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the JOF32 MEM-stage data-memory sequencer.
package mem_ctrl_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    RD_RSP = 3'd2,
    WR     = 3'd3,
    RMW_RD = 3'd4,
    RMW_WR = 3'd5,
    ERR    = 3'd6
  } state_t;

  localparam logic [1:0] LANE0 = 2'd0;
  localparam logic [1:0] LANE1 = 2'd1;
  localparam logic [1:0] LANE2 = 2'd2;
  localparam logic [1:0] LANE3 = 2'd3;

endpackage

// File: rtl/byte_lane_fmt.sv
// Little-endian byte-lane helper: zero-extended extract and single-lane merge.
module byte_lane_fmt
  import mem_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        lane,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] extracted,
  output logic [WORD_W-1:0] merged
);

  // Select one lane for loads and splice one lane in for byte stores.
  always_comb begin
    extracted = {WORD_W{1'b0}};
    merged    = word;
    case (lane)
      LANE0: begin
        extracted = {24'd0, word[7:0]};
        merged    = {word[31:8], byte_in};
      end
      LANE1: begin
        extracted = {24'd0, word[15:8]};
        merged    = {word[31:16], byte_in, word[7:0]};
      end
      LANE2: begin
        extracted = {24'd0, word[23:16]};
        merged    = {word[31:24], byte_in, word[15:0]};
      end
      LANE3: begin
        extracted = {24'd0, word[31:24]};
        merged    = {byte_in, word[23:0]};
      end
      default: begin
        extracted = {WORD_W{1'b0}};
        merged    = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// One-at-a-time load/store sequencer driving a 1-cycle-latency synchronous data RAM.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic              req_byte,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [31:0]       resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_t            state;
  logic              cap_byte;
  logic [1:0]        cap_lane;
  logic [WORD_W-1:0] cap_wdata;
  logic [WORD_W-1:0] rdata_hold;
  logic [WORD_W-1:0] lane_extracted;
  logic [WORD_W-1:0] lane_merged;
  logic [WORD_W-1:0] load_data;
  logic              accept;
  logic              misaligned;
  logic              unused_addr_bits;

  assign accept           = req_valid & req_ready;
  assign misaligned       = ~req_byte & (req_addr[1:0] != 2'b00);
  assign unused_addr_bits = ^req_addr[31:ADDR_W+2];

  byte_lane_fmt u_fmt (
    .word      (mem_rdata),
    .lane      (cap_lane),
    .byte_in   (cap_wdata[7:0]),
    .extracted (lane_extracted),
    .merged    (lane_merged)
  );

  assign load_data = cap_byte ? lane_extracted : mem_rdata;

  // RAM data is only valid during RD_RSP / RMW_WR, so those cycles bypass the held registers.
  assign resp_rdata = (state == RD_RSP) ? load_data : rdata_hold;
  assign mem_wdata  = (state == RMW_WR) ? lane_merged : cap_wdata;

  // Sequencer state and registered handshake / RAM control.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      rdata_hold <= {WORD_W{1'b0}};
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      cap_byte   <= 1'b0;
      cap_lane   <= LANE0;
      cap_wdata  <= {WORD_W{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            cap_byte  <= req_byte;
            cap_lane  <= req_addr[1:0];
            cap_wdata <= req_wdata;
            if (misaligned) begin
              state      <= ERR;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              rdata_hold <= {WORD_W{1'b0}};
            end else begin
              mem_addr <= req_addr[ADDR_W+1:2];
              if (!req_we) begin
                state <= RD;
              end else if (!req_byte) begin
                state      <= WR;
                mem_we     <= 1'b1;
                resp_valid <= 1'b1;
              end else begin
                state <= RMW_RD;
              end
            end
          end else begin
            state <= IDLE;
          end
        end
        RD: begin
          state      <= RD_RSP;
          resp_valid <= 1'b1;
        end
        RD_RSP: begin
          state      <= IDLE;
          rdata_hold <= load_data;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        WR: begin
          state      <= IDLE;
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        RMW_RD: begin
          state      <= RMW_WR;
          mem_we     <= 1'b1;
          resp_valid <= 1'b1;
        end
        RMW_WR: begin
          state      <= IDLE;
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
        end
        ERR: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          mem_we     <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural 1-cycle-latency RAM.
module tb_mem_access_ctrl;

  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic              req_byte = 1'b0;
  logic [31:0]       req_addr = 32'd0;
  logic [31:0]       req_wdata = 32'd0;
  logic              resp_valid;
  logic              resp_err;
  logic [31:0]       resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic [31:0]       ram [0:(1<<ADDR_W)-1];
  int                we_cnt = 0;
  int                resp_cnt = 0;
  int                acc_cnt = 0;
  logic [ADDR_W-1:0] last_waddr = '0;
  int                checks = 0;
  int                failures = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_byte   (req_byte),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Synchronous RAM, read-before-write, one cycle read latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // Event counters observed at each clock edge.
  always @(posedge clk) begin
    if (mem_we) begin
      we_cnt     <= we_cnt + 1;
      last_waddr <= mem_addr;
    end
    if (resp_valid) resp_cnt <= resp_cnt + 1;
    if (req_valid && req_ready && !rst) acc_cnt <= acc_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request, then wait (bounded) for its response and the return to IDLE.
  task automatic do_req(input logic we, input logic byt, input logic [31:0] addr,
                        input logic [31:0] wdata, output int lat, output int busy,
                        output logic [31:0] rd, output logic err);
    logic found;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = byt; req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1; busy = 0; found = 1'b0; rd = 32'd0; err = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      if (!req_ready) busy++;
      if (resp_valid) begin
        found = 1'b1; rd = resp_rdata; err = resp_err;
      end else begin
        @(posedge clk); #1;
        lat++;
      end
    end
    check("resp_seen", {31'd0, found}, 32'd1);
    @(posedge clk); #1;
  endtask

  int          lat, busy, we0, resp0, acc0;
  logic [31:0] rd;
  logic        err;

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 32'd0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",      {31'd0, req_ready},  32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err",   {31'd0, resp_err},   32'd0);
    check("rst_rdata",      resp_rdata,          32'd0);
    check("rst_mem_we",     {31'd0, mem_we},     32'd0);
    check("rst_mem_addr",   {22'd0, mem_addr},   32'd0);
    check("rst_mem_wdata",  mem_wdata,           32'd0);
    rst = 1'b0;

    // 1: store word then load word
    we0 = we_cnt;
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, lat, busy, rd, err);
    check("sw_lat",     lat,              32'd1);
    check("sw_err",     {31'd0, err},     32'd0);
    check("sw_we_cnt",  we_cnt - we0,     32'd1);
    check("sw_waddr",   {22'd0, last_waddr}, 32'd4);
    check("sw_ram",     ram[4],           32'hDEADBEEF);
    we0 = we_cnt;
    do_req(1'b0, 1'b0, 32'h10, 32'd0, lat, busy, rd, err);
    check("lw_lat",     lat,              32'd2);
    check("lw_rdata",   rd,               32'hDEADBEEF);
    check("lw_err",     {31'd0, err},     32'd0);
    check("lw_no_we",   we_cnt - we0,     32'd0);
    check("lw_hold",    resp_rdata,       32'hDEADBEEF);

    // 2: byte loads across lanes
    do_req(1'b1, 1'b0, 32'h20, 32'h11223344, lat, busy, rd, err);
    do_req(1'b0, 1'b1, 32'h21, 32'd0, lat, busy, rd, err);
    check("lb1_rdata", rd,  32'h00000033);
    check("lb1_lat",   lat, 32'd2);
    do_req(1'b0, 1'b1, 32'h23, 32'd0, lat, busy, rd, err);
    check("lb3_rdata", rd,  32'h00000011);
    do_req(1'b0, 1'b1, 32'h20, 32'd0, lat, busy, rd, err);
    check("lb0_rdata", rd,  32'h00000044);

    // 3: byte store via read-modify-write
    we0 = we_cnt;
    do_req(1'b1, 1'b1, 32'h22, 32'hFFFFFFAA, lat, busy, rd, err);
    check("sb_lat",    lat,          32'd2);
    check("sb_busy",   busy,         32'd2);
    check("sb_we_cnt", we_cnt - we0, 32'd1);
    check("sb_ram",    ram[8],       32'h11AA3344);
    do_req(1'b1, 1'b1, 32'h23, 32'h00000055, lat, busy, rd, err);
    check("sb3_ram",   ram[8],       32'h55AA3344);
    do_req(1'b0, 1'b0, 32'h20, 32'd0, lat, busy, rd, err);
    check("sb_readback", rd,         32'h55AA3344);

    // 4: misaligned word load
    we0 = we_cnt;
    do_req(1'b0, 1'b0, 32'h06, 32'd0, lat, busy, rd, err);
    check("err_lat",     lat,          32'd1);
    check("err_flag",    {31'd0, err}, 32'd1);
    check("err_rdata",   rd,           32'd0);
    check("err_no_we",   we_cnt - we0, 32'd0);
    check("err_cleared", {31'd0, resp_err}, 32'd0);
    check("err_ready",   {31'd0, req_ready}, 32'd1);

    // 5: reset during RMW_RD abandons the write
    we0 = we_cnt; resp0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b1; req_addr = 32'h20; req_wdata = 32'h77;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_busy",  {31'd0, req_ready}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_ready", {31'd0, req_ready},  32'd1);
    check("abort_resp",  {31'd0, resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_we",   we_cnt - we0,     32'd0);
    check("abort_no_resp", resp_cnt - resp0, 32'd0);
    check("abort_ram",     ram[8],           32'h55AA3344);

    // 6: address wrap and a request held while busy
    do_req(1'b1, 1'b0, 32'h1000, 32'hCAFEF00D, lat, busy, rd, err);
    check("wrap_waddr", {22'd0, last_waddr}, 32'd0);
    check("wrap_ram",   ram[0],              32'hCAFEF00D);
    acc0 = acc_cnt; resp0 = resp_cnt;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_byte = 1'b0; req_addr = 32'h10; req_wdata = 32'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 8 && !resp_valid; i++) begin
      @(posedge clk); #1;
    end
    check("hold_rdata", resp_rdata, 32'hDEADBEEF);
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("hold_acc_once",  acc_cnt - acc0,   32'd1);
    check("hold_resp_once", resp_cnt - resp0, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
